// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the asynchronous FIFO: pointer width derivation
// and Gray/binary conversion, used by both pointer logic and synchronizer.
package fifo_pkg;

   localparam int GRAY_MAX_W = 32;

   function automatic int ptr_w(input int depth_bit);
      return depth_bit + 1;
   endfunction

   // Operates on a zero-extended pointer; leading zeros leave the low bits exact.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b = {GRAY_MAX_W{1'b0}};
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
      return b ^ {1'b0, b[GRAY_MAX_W-1:1]};
   endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer chain: stage 0 samples d directly, q is the last stage.
module sync_chain #(
   parameter int WIDTH  = 5,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_r [STAGES];

   // Shift the sampled value down the chain; reset clears every stage at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         stage_r[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign q = stage_r[STAGES-1];

endmodule

// File: rtl/sync_addr_gray_cdc.sv
// Brings foreign-domain FIFO Gray pointers into the local clock domain and
// derives binary pointers, occupancy and empty/full status from them.
module sync_addr_gray_cdc
   import fifo_pkg::*;
#(
   parameter int FIFO_DEPTH_BIT = 4,
   parameter int SYNC_STAGES    = 2,
   localparam int PTR_W         = ptr_w(FIFO_DEPTH_BIT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PTR_W-1:0] write_addr_gray,
   input  logic [PTR_W-1:0] read_addr_gray,
   output logic [PTR_W-1:0] write_addr_gray_sync,
   output logic [PTR_W-1:0] read_addr_gray_sync,
   output logic [PTR_W-1:0] write_addr_bin_sync,
   output logic [PTR_W-1:0] read_addr_bin_sync,
   output logic [PTR_W-1:0] fifo_count,
   output logic             fifo_empty,
   output logic             fifo_full
);

   // Full means the write pointer is one lap ahead: top two Gray bits inverted.
   localparam logic [PTR_W-1:0] FULL_MASK = {2'b11, {(PTR_W-2){1'b0}}};

   logic [PTR_W-1:0] write_gray_s;
   logic [PTR_W-1:0] read_gray_s;
   logic [PTR_W-1:0] write_bin_s;
   logic [PTR_W-1:0] read_bin_s;

   sync_chain #(
      .WIDTH  (PTR_W),
      .STAGES (SYNC_STAGES)
   ) u_write_sync (
      .clk (clk),
      .rst (rst),
      .d   (write_addr_gray),
      .q   (write_gray_s)
   );

   sync_chain #(
      .WIDTH  (PTR_W),
      .STAGES (SYNC_STAGES)
   ) u_read_sync (
      .clk (clk),
      .rst (rst),
      .d   (read_addr_gray),
      .q   (read_gray_s)
   );

   assign write_bin_s = PTR_W'(gray2bin(GRAY_MAX_W'(write_gray_s)));
   assign read_bin_s  = PTR_W'(gray2bin(GRAY_MAX_W'(read_gray_s)));

   assign write_addr_gray_sync = write_gray_s;
   assign read_addr_gray_sync  = read_gray_s;
   assign write_addr_bin_sync  = write_bin_s;
   assign read_addr_bin_sync   = read_bin_s;

   // Modulo-2^PTR_W subtraction keeps the count correct across pointer wrap.
   assign fifo_count = write_bin_s - read_bin_s;
   assign fifo_empty = (write_gray_s == read_gray_s);
   assign fifo_full  = (write_gray_s == (read_gray_s ^ FULL_MASK));

endmodule

// File: tb/tb_sync_addr_gray_cdc.sv
// Self-checking bench for sync_addr_gray_cdc: directed steps plus random
// pointer traffic, checked against an input-history reference model.
module tb_sync_addr_gray_cdc;

   localparam int DB = 4;
   localparam int ST = 2;
   localparam int W  = DB + 1;

   logic         clk;
   logic         rst;
   logic [W-1:0] wg;
   logic [W-1:0] rg;
   logic [W-1:0] w_sync;
   logic [W-1:0] r_sync;
   logic [W-1:0] w_bin;
   logic [W-1:0] r_bin;
   logic [W-1:0] count;
   logic         empty;
   logic         full;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: value on each input at every rising edge.
   logic [W-1:0] w_hist [0:4095];
   logic [W-1:0] r_hist [0:4095];
   int edge_n     = 0;
   int valid_from = 1;

   sync_addr_gray_cdc #(
      .FIFO_DEPTH_BIT (DB),
      .SYNC_STAGES    (ST)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .write_addr_gray      (wg),
      .read_addr_gray       (rg),
      .write_addr_gray_sync (w_sync),
      .read_addr_gray_sync  (r_sync),
      .write_addr_bin_sync  (w_bin),
      .read_addr_bin_sync   (r_bin),
      .fifo_count           (count),
      .fifo_empty           (empty),
      .fifo_full            (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] to_gray(input int b);
      return W'(b ^ (b >> 1));
   endfunction

   function automatic int to_bin(input logic [W-1:0] g);
      int b = 0;
      for (int k = 0; k < W; k++) b = b ^ (int'(g) >> k);
      return b;
   endfunction

   // A value shows up SYNC_STAGES edges after it is sampled, i.e. it is the
   // value sampled ST-1 edges before the most recent one.
   function automatic logic [W-1:0] exp_ptr(input bit is_write);
      int idx = edge_n - (ST - 1);
      if (idx < valid_from) return '0;
      return is_write ? w_hist[idx] : r_hist[idx];
   endfunction

   task automatic check(input string tag, input string field, input int got, input int exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s.%s: got %0h expected %0h", tag, field, got, exp);
   endtask

   task automatic check_all(input string tag);
      logic [W-1:0] ew = exp_ptr(1'b1);
      logic [W-1:0] er = exp_ptr(1'b0);
      int wb  = to_bin(ew);
      int rb  = to_bin(er);
      int cnt = (wb - rb + (1 << W)) % (1 << W);
      check(tag, "w_sync", int'(w_sync), int'(ew));
      check(tag, "r_sync", int'(r_sync), int'(er));
      check(tag, "w_bin",  int'(w_bin),  wb);
      check(tag, "r_bin",  int'(r_bin),  rb);
      check(tag, "count",  int'(count),  cnt);
      check(tag, "empty",  int'(empty),  int'(cnt == 0));
      check(tag, "full",   int'(full),   int'(cnt == (1 << DB)));
   endtask

   task automatic tick();
      @(posedge clk);
      edge_n++;
      w_hist[edge_n] = wg;
      r_hist[edge_n] = rg;
      if (rst) valid_from = edge_n + 1;
      #1;
   endtask

   task automatic raise_reset();
      rst = 1'b1;
      valid_from = edge_n + 1;
   endtask

   initial begin
      // Reset with non-zero inputs present
      wg = 5'b00101;
      rg = 5'b00101;
      raise_reset();
      #1;
      check_all("reset_t0");
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all("reset_hold");
         check("reset_hold", "count_const", int'(count), 0);
      end

      // Release between edges, then latency of a single step
      #4;
      rst = 1'b0;
      wg  = 5'b00000;
      rg  = 5'b00000;
      tick();
      check_all("release");
      tick();
      check_all("release");
      wg = 5'b00001;
      tick();
      check_all("lat_edge1");
      check("lat_edge1", "w_sync_const", int'(w_sync), 0);
      tick();
      check_all("lat_edge2");
      check("lat_edge2", "w_sync_const", int'(w_sync), 1);

      // Sweep write pointer through one full lap, read pointer at 0
      for (int i = 0; i < 32; i++) begin
         wg = to_gray(i);
         tick();
         check_all("sweep");
      end
      tick();
      check_all("sweep_tail");
      tick();
      check_all("sweep_tail");
      check("sweep_tail", "w_bin_const", int'(w_bin), 31);

      // Wrap-around with both pointers equal
      wg = 5'b10000;
      rg = 5'b10000;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all("wrap_hi");
      end
      wg = 5'b00000;
      rg = 5'b00000;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all("wrap_lo");
         check("wrap_lo", "empty_const", int'(empty), 1);
         check("wrap_lo", "count_const", int'(count), 0);
      end

      // Random pointer traffic, any value pair
      for (int i = 0; i < 200; i++) begin
         wg = W'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) rg = wg;
         else rg = W'($urandom_range(0, 31));
         tick();
         check_all("random");
      end

      // Asynchronous reset mid-operation
      wg = to_gray(9);
      rg = to_gray(3);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all("pre_reset");
      end
      check("pre_reset", "count_const", int'(count), 6);
      #2;
      raise_reset();
      #1;
      check_all("async_reset");
      check("async_reset", "empty_const", int'(empty), 1);
      check("async_reset", "count_const", int'(count), 0);
      tick();
      check_all("async_reset_hold");
      #3;
      rst = 1'b0;
      tick();
      check_all("post_reset");
      tick();
      check_all("post_reset");
      tick();
      check_all("post_reset");

      // Independence: only the read pointer moves
      wg = to_gray(5);
      rg = to_gray(0);
      tick();
      tick();
      check_all("indep_setup");
      rg = to_gray(2);
      tick();
      check_all("indep_edge1");
      check("indep_edge1", "w_sync_const", int'(w_sync), int'(to_gray(5)));
      check("indep_edge1", "r_sync_const", int'(r_sync), 0);
      tick();
      check_all("indep_edge2");
      check("indep_edge2", "w_sync_const", int'(w_sync), int'(to_gray(5)));
      check("indep_edge2", "r_sync_const", int'(r_sync), int'(to_gray(2)));
      check("indep_edge2", "count_const", int'(count), 3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
